hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer-side companion to the forwarding control in the 5-stage core.
- Shadows destination-register tags down EX/MEM/WB and supplies last_rd, mem_rd and wb_rd to the forwarding logic.
- Detects load-use hazards the forwarding board cannot cover, and generates stall (hold IF/ID) and bubble (inject NOP into EX).
- Freezes the shadow pipeline while the data memory is busy.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LATENCY, 1, stall cycles per load-use hazard; legal range 1..7.

Ports:
- clk  in  1  core clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  Decode holds a real instruction.
- id_rs1  in  REG_AW  Decode source 1.
- id_rs2  in  REG_AW  Decode source 2.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_AW  Decode destination.
- id_rd_we  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  taken branch/jump; kills ID and EX.
- mem_busy  in  1  data memory not ready; freeze pipeline.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  EX receives a NOP this cycle.
- last_rd  out  REG_AW  EX-stage destination, 0 if none.
- mem_rd  out  REG_AW  MEM-stage destination, 0 if none.
- wb_rd  out  REG_AW  WB-stage destination, 0 if none.
- wb_we  out  1  WB-stage entry writes the register file.

Behaviour:
- Shadow stages EX, MEM, WB each hold {valid, rd, we, is_load}.
  - An entry counts as writing only when valid & we & rd != 0.
  - last_rd, mem_rd and wb_rd output rd when the entry is writing, else 0. They are driven straight from flops with no combinational path from inputs.
- Reset (reset=0, async):
  - All stage valids = 0; state = RUN; counter = 0.
  - Outputs: stall=0, bubble=0, last_rd=0, mem_rd=0, wb_rd=0, wb_we=0.
- Hazard condition: id_valid & EX writing & EX.is_load & ((id_use_rs1 & id_rs1==EX.rd) | (id_use_rs2 & id_rs2==EX.rd)). x0 never hazards.
- FSM states are RUN, LOAD_STALL and MEM_WAIT.
  - stall and bubble are combinational from state, counter and inputs. Transitions are registered.
- Event priority: reset > mem_busy > flush > hazard/LOAD_STALL > normal advance.
- mem_busy=1, any state:
  - stall=1, bubble=0; all shadow stages hold.
  - State moves to MEM_WAIT, and the pre-freeze state and counter are saved.
  - When mem_busy falls, the saved state and counter are restored on the next edge. The hazard check is re-evaluated in that cycle.
- flush=1 without mem_busy:
  - The EX entry is loaded invalid and the ID instruction is dropped: bubble=1, stall=0.
  - MEM <= EX and WB <= MEM still advance.
  - Any LOAD_STALL is cancelled; state = RUN; counter = 0.
- RUN with hazard:
  - stall=1, bubble=1; EX <= invalid, MEM <= EX, WB <= MEM.
  - If LOAD_LATENCY==1, stay in RUN. The dependent instruction issues next cycle and forwards from MEM.
  - Otherwise go to LOAD_STALL with counter = LOAD_LATENCY-1.
- LOAD_STALL:
  - stall=1, bubble=1, and stages advance with a bubble into EX.
  - The counter decrements each cycle; the FSM exits to RUN on the edge where counter==1.
  - Total stall cycles = LOAD_LATENCY.
- RUN, no hazard:
  - stall=0, bubble=0.
  - EX <= {id_valid, id_rd, id_rd_we, id_is_load}; MEM <= EX; WB <= MEM.
- Back-to-back loads are handled by the hazard rule alone; no extra state is needed.
- Reset asserted mid-stall or mid-freeze clears everything immediately. The first cycle after reset release is RUN with empty stages.
- wb_we = WB.valid & WB.we & (WB.rd != 0).

Decomposition:
- Shared pipeline package holds:
  - REG_AW;
  - the stage-entry struct {valid, rd, we, is_load};
  - the FSM state enum {RUN, LOAD_STALL, MEM_WAIT};
  - the constant REG_ZERO = 0.
- One natural sub-module, hazard_detect: a purely combinational comparator taking the EX entry and the id_* inputs and returning the hazard flag. It mirrors forwardingBoard on the producer side.

Test Plan:
- Reset with reset=0 mid-operation -> all outputs 0 asynchronously, before any clock edge. After release, an ADD with rd=5 in ID gives last_rd=5 next cycle, mem_rd=5 the cycle after, then wb_rd=5 with wb_we=1.
- LW x3 followed by ADD x4,x3,x1 with LOAD_LATENCY=1 -> exactly one cycle of stall=1, bubble=1. On that cycle last_rd=3; next cycle last_rd=0 and mem_rd=3; then the ADD issues.
- LOAD_LATENCY=3 with the same pair -> stall high for 3 consecutive cycles, then the ADD enters EX with last_rd=4.
- LW x0 followed by ADD x4,x0,x0, and separately LW x3 followed by ADDI x4,x1,imm with id_use_rs2=0 -> no stall in either case.
- Hazard active with mem_busy=1 for 4 cycles -> stall=1, bubble=0, and last_rd/mem_rd/wb_rd frozen for those 4 cycles. After release the load-use stall completes normally.
- flush=1 during LOAD_STALL (LOAD_LATENCY=3, second stall cycle) -> bubble=1, stall=0, state back to RUN; no further stall cycles.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline types for the producer-side hazard scoreboard.
// Holds the register width, the shadow stage entry, the FSM states and a helper that reports whether an entry writes.
package hazard_scoreboard_pkg;

    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              is_load;
    } stage_t;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_e;

    localparam stage_t STAGE_EMPTY = '0;

    function automatic logic entry_writes(input stage_t s);
        return s.valid & s.we & (s.rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_detect.sv
// Load-use comparator: EX holds a writing load whose rd matches a source that decode actually reads.
// Purely combinational, zero latency, no flow control.
module hazard_detect
    import hazard_scoreboard_pkg::*;
(
    input  stage_t            ex,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    output logic              hazard
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = id_use_rs1 & (id_rs1 == ex.rd);
        rs2_hit = id_use_rs2 & (id_rs2 == ex.rd);
        // entry_writes already excludes x0, so a zero source never matches a live producer
        hazard  = id_valid & entry_writes(ex) & ex.is_load & (rs1_hit | rs2_hit);
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Shadows rd tags down EX/MEM/WB, stalls/bubbles on load-use hazards and freezes on mem_busy.
// Tag outputs are registered (one cycle); stall/bubble are same-cycle combinational.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int LOAD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_rd_we,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              mem_busy,
    output logic              stall,
    output logic              bubble,
    output logic [REG_AW-1:0] last_rd,
    output logic [REG_AW-1:0] mem_rd,
    output logic [REG_AW-1:0] wb_rd,
    output logic              wb_we
);

    localparam logic [2:0] LAT_M1 = 3'(LOAD_LATENCY - 1);

    state_e            state_q, state_d, sav_state_q, sav_state_d, cur_state;
    logic   [2:0]      cnt_q, cnt_d, sav_cnt_q, sav_cnt_d, cur_cnt;
    stage_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [REG_AW-1:0] last_rd_q, last_rd_d, mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic              wb_we_q, wb_we_d;
    logic              hazard;
    logic              stall_c, bubble_c;

    hazard_detect u_detect (
        .ex         (ex_q),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .hazard     (hazard)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sav_state_d = sav_state_q;
        sav_cnt_d   = sav_cnt_q;
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_c     = 1'b0;
        bubble_c    = 1'b0;
        // The cycle after a freeze acts on the restored context directly
        cur_state   = (state_q == MEM_WAIT) ? sav_state_q : state_q;
        cur_cnt     = (state_q == MEM_WAIT) ? sav_cnt_q : cnt_q;

        if (mem_busy) begin
            stall_c = 1'b1;
            state_d = MEM_WAIT;
            if (state_q != MEM_WAIT) begin
                sav_state_d = state_q;
                sav_cnt_d   = cnt_q;
            end
        end else begin
            mem_d = ex_q;
            wb_d  = mem_q;
            ex_d  = STAGE_EMPTY;
            if (flush) begin
                bubble_c = 1'b1;
                state_d  = RUN;
                cnt_d    = '0;
            end else if (cur_state == LOAD_STALL) begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                cnt_d    = cur_cnt - 3'd1;
                state_d  = (cur_cnt == 3'd1) ? RUN : LOAD_STALL;
            end else if (hazard) begin
                stall_c  = 1'b1;
                bubble_c = 1'b1;
                state_d  = (LOAD_LATENCY == 1) ? RUN : LOAD_STALL;
                cnt_d    = LAT_M1;
            end else begin
                ex_d    = '{valid: id_valid, rd: id_rd, we: id_rd_we, is_load: id_is_load};
                state_d = RUN;
                cnt_d   = '0;
            end
        end

        last_rd_d = entry_writes(ex_d) ? ex_d.rd : REG_ZERO;
        mem_rd_d  = entry_writes(mem_d) ? mem_d.rd : REG_ZERO;
        wb_rd_d   = entry_writes(wb_d) ? wb_d.rd : REG_ZERO;
        wb_we_d   = entry_writes(wb_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            sav_state_q <= RUN;
            sav_cnt_q   <= '0;
            ex_q        <= STAGE_EMPTY;
            mem_q       <= STAGE_EMPTY;
            wb_q        <= STAGE_EMPTY;
            last_rd_q   <= REG_ZERO;
            mem_rd_q    <= REG_ZERO;
            wb_rd_q     <= REG_ZERO;
            wb_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sav_state_q <= sav_state_d;
            sav_cnt_q   <= sav_cnt_d;
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            last_rd_q   <= last_rd_d;
            mem_rd_q    <= mem_rd_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
        end
    end

    // Reset dominates: a busy memory must not raise stall while the core is held in reset
    assign stall   = stall_c & reset;
    assign bubble  = bubble_c & reset;
    assign last_rd = last_rd_q;
    assign mem_rd  = mem_rd_q;
    assign wb_rd   = wb_rd_q;
    assign wb_we   = wb_we_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with LOAD_LATENCY 1 and 3 instances fed identical stimulus.
module tb_hazard_scoreboard;

    typedef struct {
        int         tag;
        bit         sel3;
        logic       stall;
        logic       bubble;
        logic [4:0] last_rd;
        logic [4:0] mem_rd;
        logic [4:0] wb_rd;
        logic       wb_we;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       id_rd_we = 1'b0, id_is_load = 1'b0, flush = 1'b0, mem_busy = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

    logic       stall1, bubble1, wb_we1, stall3, bubble3, wb_we3;
    logic [4:0] last1, mem1, wb1, last3, mem3, wb3;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   ph = 0;
    int   cn = 0;
    bit   done = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.LOAD_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .flush(flush), .mem_busy(mem_busy), .stall(stall1),
        .bubble(bubble1), .last_rd(last1), .mem_rd(mem1), .wb_rd(wb1), .wb_we(wb_we1)
    );

    hazard_scoreboard #(.LOAD_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .flush(flush), .mem_busy(mem_busy), .stall(stall3),
        .bubble(bubble3), .last_rd(last3), .mem_rd(mem3), .wb_rd(wb3), .wb_we(wb_we3)
    );

    // Monitor: one expected entry per cycle, compared at the falling edge
    initial begin
        exp_t       e;
        logic [17:0] got, want;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e    = q.pop_front();
                want = {e.stall, e.bubble, e.last_rd, e.mem_rd, e.wb_rd, e.wb_we};
                if (e.sel3) got = {stall3, bubble3, last3, mem3, wb3, wb_we3};
                else        got = {stall1, bubble1, last1, mem1, wb1, wb_we1};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL chk%0d LL=%0d got stall=%b bubble=%b last=%0d mem=%0d wb=%0d we=%b expected stall=%b bubble=%b last=%0d mem=%0d wb=%0d we=%b",
                             e.tag, e.sel3 ? 3 : 1, got[17], got[16], got[15:11], got[10:6], got[5:1], got[0],
                             want[17], want[16], want[15:11], want[10:6], want[5:1], want[0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idi(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic we, input logic ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        id_rd = rd; id_rd_we = we; id_is_load = ld;
    endtask

    task automatic nop();                                      idi(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic lw(input logic [4:0] rd, input logic [4:0] rs1);   idi(1, rs1, 0, 1, 0, rd, 1, 1); endtask
    task automatic add(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b); idi(1, a, b, 1, 1, rd, 1, 0); endtask
    task automatic addi(input logic [4:0] rd, input logic [4:0] a);   idi(1, a, 5'd3, 1, 0, rd, 1, 0); endtask

    task automatic chk(input bit s3, input logic st, input logic bu, input logic [4:0] lr,
                       input logic [4:0] mr, input logic [4:0] wr, input logic we);
        exp_t e;
        e.tag = ph * 100 + cn; e.sel3 = s3; e.stall = st; e.bubble = bu;
        e.last_rd = lr; e.mem_rd = mr; e.wb_rd = wr; e.wb_we = we;
        q.push_back(e);
        cn++;
    endtask

    // Hold reset for one cycle (checking the cleared state), then release on the next cycle
    task automatic start_phase(input int p, input bit s3);
        ph = p; cn = 0;
        cyc(); reset = 1'b0; flush = 0; mem_busy = 0; nop(); chk(s3, 0, 0, 0, 0, 0, 0);
        cyc(); reset = 1'b1;
    endtask

    initial begin
        // Mid-operation async reset, then tag propagation after release
        ph = 1;
        cyc(); reset = 1'b1; add(7, 1, 2);  chk(0, 0, 0, 0, 0, 0, 0);
        cyc(); nop();                       chk(0, 0, 0, 7, 0, 0, 0);
        cyc();                              chk(0, 0, 0, 0, 7, 0, 0);
        cyc(); reset = 1'b0; mem_busy = 1; lw(3, 1); chk(0, 0, 0, 0, 0, 0, 0);
        cyc(); reset = 1'b1; mem_busy = 0; add(5, 1, 2); chk(0, 0, 0, 0, 0, 0, 0);
        cyc(); nop();                       chk(0, 0, 0, 5, 0, 0, 0);
        cyc();                              chk(0, 0, 0, 0, 5, 0, 0);
        cyc();                              chk(0, 0, 0, 0, 0, 5, 1);

        // LOAD_LATENCY=1 load-use
        start_phase(2, 0);
        lw(3, 1);        chk(0, 0, 0, 0, 0, 0, 0);
        cyc(); add(4, 3, 1); chk(0, 1, 1, 3, 0, 0, 0);
        cyc();           chk(0, 0, 0, 0, 3, 0, 0);
        cyc(); nop();    chk(0, 0, 0, 4, 0, 3, 1);
        cyc();           chk(0, 0, 0, 0, 4, 0, 0);
        cyc();           chk(0, 0, 0, 0, 0, 4, 1);

        // LOAD_LATENCY=3 load-use
        start_phase(3, 1);
        lw(3, 1);        chk(1, 0, 0, 0, 0, 0, 0);
        cyc(); add(4, 3, 1); chk(1, 1, 1, 3, 0, 0, 0);
        cyc();           chk(1, 1, 1, 0, 3, 0, 0);
        cyc();           chk(1, 1, 1, 0, 0, 3, 1);
        cyc();           chk(1, 0, 0, 0, 0, 0, 0);
        cyc(); nop();    chk(1, 0, 0, 4, 0, 0, 0);
        cyc();           chk(1, 0, 0, 0, 4, 0, 0);

        // No hazard: x0 producer, and unused rs2 matching the load
        start_phase(4, 0);
        lw(0, 1);        chk(0, 0, 0, 0, 0, 0, 0);
        cyc(); add(4, 0, 0); chk(0, 0, 0, 0, 0, 0, 0);
        cyc(); lw(3, 1); chk(0, 0, 0, 4, 0, 0, 0);
        cyc(); addi(4, 1); chk(0, 0, 0, 3, 4, 0, 0);
        cyc(); nop();    chk(0, 0, 0, 4, 3, 4, 1);

        // Hazard under a 4-cycle memory freeze, LOAD_LATENCY=3
        start_phase(5, 1);
        add(6, 1, 2);    chk(1, 0, 0, 0, 0, 0, 0);
        cyc(); add(7, 1, 2); chk(1, 0, 0, 6, 0, 0, 0);
        cyc(); lw(3, 1); chk(1, 0, 0, 7, 6, 0, 0);
        cyc(); add(4, 3, 1); mem_busy = 1; chk(1, 1, 0, 3, 7, 6, 1);
        for (int i = 0; i < 3; i++) begin
            cyc();       chk(1, 1, 0, 3, 7, 6, 1);
        end
        cyc(); mem_busy = 0; chk(1, 1, 1, 3, 7, 6, 1);
        cyc();           chk(1, 1, 1, 0, 3, 7, 1);
        cyc();           chk(1, 1, 1, 0, 0, 3, 1);
        cyc();           chk(1, 0, 0, 0, 0, 0, 0);
        cyc(); nop();    chk(1, 0, 0, 4, 0, 0, 0);

        // Flush on the second stall cycle cancels the rest, LOAD_LATENCY=3
        start_phase(6, 1);
        lw(3, 1);        chk(1, 0, 0, 0, 0, 0, 0);
        cyc(); add(4, 3, 1); chk(1, 1, 1, 3, 0, 0, 0);
        cyc(); flush = 1; chk(1, 0, 1, 0, 3, 0, 0);
        cyc(); flush = 0; add(5, 1, 2); chk(1, 0, 0, 0, 0, 3, 1);
        cyc(); nop();    chk(1, 0, 0, 5, 0, 0, 0);

        cyc();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: bench still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule
